// File: rtl/kbd_pkg.sv
// kbd_pkg: shared state encoding and data width for the keyboard FIFO arbiter
package kbd_pkg;
  localparam int KBD_DW = 8;
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, RESP, FLUSH, WAIT} kbd_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick, first set req bit at or after ptr (wrapping)
// Ports: req (request vector), ptr (priority pointer), gnt (one-hot grant, 0 if no req), idx (granted index)
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  logic [NREQ-1:0] rot;
  logic [IW-1:0] off;
  logic [IW:0] sum;
  always_comb begin
    rot = NREQ'({req, req} >> ptr);
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (rot[IW'(i)]) off = IW'(i);
    sum = {1'b0, ptr} + {1'b0, off};
    idx = sum >= (IW+1)'(NREQ) ? IW'(sum - (IW+1)'(NREQ)) : sum[IW-1:0];
    gnt = |req ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/kbd_fifo_arbiter.sv
// kbd_fifo_arbiter: round-robin sharing of the keyboard FIFO read port with flush sequencing
// Ports: clk, rst_n (async active-low), req/ack (per-requester level request / one-cycle ack),
//   rsp_data (read result, 0 = empty), flush (clear request), fifo_rden/fifo_rst/fifo_data (FIFO side), busy.
// Option: define KBD_ARB_BLOCK_EN to re-poll an empty FIFO every POLL_GAP cycles instead of acking 0.
module kbd_fifo_arbiter
  import kbd_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW = KBD_DW,
  parameter int POLL_GAP = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ack,
  output logic [DW-1:0]   rsp_data,
  input  logic            flush,
  output logic            fifo_rden,
  output logic            fifo_rst,
  input  logic [DW-1:0]   fifo_data,
  output logic            busy
);
  localparam int IW = $clog2(NREQ);
  kbd_state_t state;
  logic [IW-1:0] ptr, g, pick_idx;
  logic [NREQ-1:0] gnt, pick_gnt;
  logic pend;
`ifdef KBD_ARB_BLOCK_EN
  localparam int CW = $clog2(POLL_GAP + 1);
  logic [CW-1:0] cnt;
`endif
  rr_pick #(.NREQ(NREQ)) u_pick (.req(req), .ptr(ptr), .gnt(pick_gnt), .idx(pick_idx));
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ack <= '0;
      rsp_data <= '0;
      fifo_rden <= 1'b0;
      fifo_rst <= 1'b0;
      ptr <= '0;
      g <= '0;
      gnt <= '0;
      pend <= 1'b0;
`ifdef KBD_ARB_BLOCK_EN
      cnt <= '0;
`endif
    end else begin
      fifo_rden <= 1'b0;
      fifo_rst <= 1'b0;
      ack <= '0;
      // flushes outside IDLE wait here so the in-flight grant completes; repeats merge
      pend <= pend | flush;
      case (state)
        IDLE:
          if (flush || pend) begin
            state <= FLUSH;
            fifo_rst <= 1'b1;
            pend <= 1'b0;
          end else if (|req) begin
            state <= ISSUE;
            fifo_rden <= 1'b1;
            g <= pick_idx;
            gnt <= pick_gnt;
          end
        ISSUE: state <= CAPTURE;
`ifdef KBD_ARB_BLOCK_EN
        CAPTURE:
          if (fifo_data == '0) begin
            state <= WAIT;
            cnt <= '0;
          end else begin
            state <= RESP;
            rsp_data <= fifo_data;
            ack <= gnt;
          end
        WAIT:
          if (!req[g] || pend || flush) state <= IDLE;
          else if (cnt == CW'(POLL_GAP - 1)) begin
            state <= ISSUE;
            fifo_rden <= 1'b1;
          end else cnt <= cnt + 1'b1;
`else
        CAPTURE: begin
          state <= RESP;
          rsp_data <= fifo_data;
          ack <= gnt;
        end
`endif
        RESP: begin
          state <= IDLE;
          ptr <= g == IW'(NREQ - 1) ? '0 : g + 1'b1;
        end
        FLUSH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/kbd_fifo_arbiter.md
Name: kbd_fifo_arbiter

Overview:
- Shares the single read port of the keyboard ASCII FIFO between NREQ requesters, e.g. the CPU MMIO load path (req 0) and the console echo engine (req 1).
- Sequences each FIFO read as rden pulse → data capture → response, grants requesters round-robin, and drives the FIFO's synchronous flush.
- Sits between the PS/2 keyboard FIFO and the bus/console logic, in the FIFO read-clock domain.

Parameters:
- NREQ, 2, number of requesters (2..4).
- DW, 8, data width; matches FIFO ASCII width.
- POLL_GAP, 16, idle cycles between re-polls in blocking mode (only used with KBD_ARB_BLOCK_EN).

Ports:
- clk  input  1  clock; also drives the FIFO read clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  NREQ  per-requester read request; level, held until ack.
- ack  output  NREQ  one-cycle pulse per requester; rsp_data is valid in that cycle.
- rsp_data  output  DW  read result; 0 = FIFO empty.
- flush  input  1  single-cycle request to clear the FIFO.
- fifo_rden  output  1  FIFO read enable.
- fifo_rst  output  1  FIFO synchronous reset (active-high).
- fifo_data  input  DW  FIFO dataout; registered by the FIFO, 0 when no read or empty.
- busy  output  1  high in every state other than IDLE.

Behaviour:
- Reset: on rst_n low, asynchronously:
  - state = IDLE; ack = 0, rsp_data = 0, fifo_rden = 0, fifo_rst = 0, busy = 0.
  - RR pointer = 0 (requester 0 has highest priority first).
- States: IDLE, ISSUE, CAPTURE, RESP, FLUSH (plus WAIT with KBD_ARB_BLOCK_EN).
- IDLE:
  - flush = 1 → FLUSH; flush wins over any req in the same cycle.
  - Otherwise, any req bit set → latch the granted index g (first set bit at or after the RR pointer, wrapping) → ISSUE.
- ISSUE: fifo_rden = 1 for exactly one cycle → CAPTURE.
- CAPTURE: fifo_data now reflects the read; register it into rsp_data → RESP.
- RESP:
  - ack[g] = 1 for one cycle, rsp_data held.
  - RR pointer = (g+1) mod NREQ, then → IDLE.
  - rsp_data stays stable until the next RESP; it is not cleared in IDLE.
- Latency: req seen in IDLE → ack in 3 cycles (ISSUE, CAPTURE, RESP). Minimum req-to-req period per requester is 4 cycles.
- One FIFO read per grant. An empty FIFO returns rsp_data = 0 with a normal ack; the grant is not retried.
- req drops before its ack: the grant still completes, and the popped byte is discarded with that ack. ack is driven regardless of req. The requester must ignore an unexpected ack.
- req still high in the cycle after ack: treated as a new request, subject to RR order.
- FLUSH:
  - fifo_rst = 1 for exactly one cycle, then → IDLE.
  - A flush arriving in ISSUE/CAPTURE/RESP is latched in a pending bit and taken at the next IDLE, so the in-flight grant always completes.
  - A second flush while one is pending is merged into it.
- Mid-operation rst_n assertion: abort immediately, all outputs go to reset values, no ack is issued. The FIFO is not flushed by this block.
- fifo_rden and fifo_rst are never high in the same cycle.

Optional Feature:
- Macro: KBD_ARB_BLOCK_EN.
- Defined:
  - A CAPTURE that returns 0 goes to WAIT instead of RESP.
  - WAIT counts POLL_GAP cycles, then → ISSUE (re-poll) for the same g, no ack.
  - In WAIT: if req[g] drops, abandon the grant (no ack) → IDLE. If flush is pending, abandon → IDLE, and FLUSH is taken next.
  - Only non-zero data is acked. Other requesters wait; starvation while the FIFO is empty is accepted behaviour.
- Undefined: WAIT and its counter do not exist; empty reads ack with 0 as described above.

Decomposition:
- Shared package kbd_pkg: state encoding constants (IDLE, ISSUE, CAPTURE, RESP, FLUSH, WAIT) and KBD_DW = 8.
- One sub-module: rr_pick. It is combinational: inputs req vector and pointer, outputs one-hot grant and index.
- Poll counter, flush-pending bit and FSM stay in the top module.

Test Plan:
- FIFO holds 'A'(0x41); req = 01 at t0 → fifo_rden high at t0+1, ack = 01 with rsp_data = 0x41 at t0+3.
- req = 11 held, FIFO holds 0x41, 0x42, 0x43 → acks alternate 01 (0x41), 10 (0x42), 01 (0x43), 4 cycles apart.
- Empty FIFO, req = 10 → ack = 10 with rsp_data = 0x00 at t0+3; with BLOCK_EN, no ack; fifo_rden re-pulses every POLL_GAP+2 cycles until 0x61 is written, then ack with 0x61.
- flush and req = 01 in the same IDLE cycle → fifo_rst one cycle, then the request is served and returns 0x00.
- flush asserted during CAPTURE → current ack completes, then fifo_rst pulses in the cycle after RESP+IDLE.
- rst_n low during CAPTURE → ack never pulses; all outputs 0 asynchronously; after release, req = 01 is served normally.
